// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver (and the future transmitter).
//   parity_e   : parity mode encoding (none / even / odd)
//   rx_state_e : receiver FSM states (BREAK exists only with UART_RX_BREAK_DETECT_EN)
//   calc_div   : clock cycles per oversample tick
// Optional feature macro: UART_RX_BREAK_DETECT_EN
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    BREAK
`endif
  } rx_state_e;

  // Depth of the input synchroniser chain.
  localparam int SYNC_STAGES = 2;

  // Clock cycles per oversample tick (integer division, rounds down).
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle oversample tick
// every DIV clocks. A synchronous clear restarts the period so the next tick
// lands exactly DIV clocks after the clear.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   clr   in  restart the period (no tick in the clearing cycle)
//   tick  out one-cycle pulse every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || (cnt_reg == CNT_LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST) && !clr;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with 3-sample majority voting and a
// valid/ready output handshake.
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx_i        in   raw serial line (asynchronous, idles high)
//   data        out  received payload, LSB = first bit on the wire
//   valid       out  data and flags available
//   ready       in   consumer accepts current data
//   parity_err  out  parity mismatch of presented frame (qualified by valid)
//   framing_err out  a stop bit was sampled low (qualified by valid)
//   overrun     out  one-cycle pulse: completed frame dropped, output occupied
//   busy        out  FSM not in IDLE
//   break_o     out  (UART_RX_BREAK_DETECT_EN only) line-break in progress
// Optional feature macro: UART_RX_BREAK_DETECT_EN -- an all-zero frame with a
// low stop bit is swallowed and reported on break_o until the line goes high.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 break_o
`endif
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OS_W = $clog2(OVERSAMPLE);

  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  // Three samples straddle the bit centre; the vote is taken on the third.
  localparam logic [OS_W-1:0] SAMP_A  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP_B  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SAMP_C  = OS_W'(OVERSAMPLE / 2 + 1);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam parity_e    PAR_MODE  = parity_e'(PARITY);

  // Elaboration-time parameter checks.
  if (DIV < 2) begin : g_chk_div
    $error("uart_rx_cfg: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_chk_os
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_db
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_chk_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   rx_s;
  logic                   fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_i};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
  // Edge, not level: a line parked low cannot start a new frame.
  assign fall = prev_reg & ~rx_s;

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  logic tick;
  logic tick_clr;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_e              state_reg, state_next;
  logic [OS_W-1:0]        os_cnt_reg, os_cnt_next;
  logic [3:0]             bit_cnt_reg, bit_cnt_next;
  logic [1:0]             samp_reg, samp_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_bit_reg, par_bit_next;
  logic                   ferr_acc_reg, ferr_acc_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   perr_reg, perr_next;
  logic                   ferr_reg, ferr_next;
  logic                   overrun_reg, overrun_next;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                   break_reg, break_next;
`endif

  logic                   vote;
  logic                   vote_now;
  logic [OS_W-1:0]        os_inc;
  logic                   complete;
  logic                   frame_perr;
  logic                   frame_ferr;
  logic                   frame_is_break;
  logic                   deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      os_cnt_reg   <= '0;
      bit_cnt_reg  <= '0;
      samp_reg     <= '0;
      shift_reg    <= '0;
      par_bit_reg  <= 1'b0;
      ferr_acc_reg <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      os_cnt_reg   <= os_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      samp_reg     <= samp_next;
      shift_reg    <= shift_next;
      par_bit_reg  <= par_bit_next;
      ferr_acc_reg <= ferr_acc_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
      overrun_reg  <= overrun_next;
`ifdef UART_RX_BREAK_DETECT_EN
      break_reg    <= break_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    os_cnt_next    = os_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    samp_next      = samp_reg;
    shift_next     = shift_reg;
    par_bit_next   = par_bit_reg;
    ferr_acc_next  = ferr_acc_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    perr_next      = perr_reg;
    ferr_next      = ferr_reg;
    overrun_next   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    break_next     = break_reg;
`endif
    tick_clr       = 1'b0;
    vote_now       = 1'b0;
    complete       = 1'b0;
    frame_is_break = 1'b0;

    vote   = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
    os_inc = (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;

    // Tick index counts ticks since the start edge modulo OVERSAMPLE, so the
    // sample points sit symmetrically around the nominal bit centre.
    if ((state_reg != IDLE) && tick) begin
      os_cnt_next = os_inc;
      if (os_inc == SAMP_A) samp_next[0] = rx_s;
      if (os_inc == SAMP_B) samp_next[1] = rx_s;
      if (os_inc == SAMP_C) vote_now = 1'b1;
    end

    // Frame flags as they stand once the last stop bit has been voted.
    frame_ferr = ferr_acc_reg | ~vote;
    frame_perr = (PAR_MODE != PAR_NONE) &&
                 ((^shift_reg ^ par_bit_reg) != (PAR_MODE == PAR_ODD));

    case (state_reg)
      IDLE: begin
        if (fall) begin
          state_next    = START;
          tick_clr      = 1'b1;
          os_cnt_next   = '0;
          bit_cnt_next  = '0;
          par_bit_next  = 1'b0;
          ferr_acc_next = 1'b0;
        end
      end
      START: begin
        if (vote_now) begin
          state_next = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (vote_now) begin
          shift_next = {vote, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next = '0;
            state_next   = (PAR_MODE == PAR_NONE) ? STOP : PAR;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      PAR: begin
        if (vote_now) begin
          par_bit_next = vote;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (vote_now) begin
          // Complete at the mid-bit vote so a following start edge is caught.
          if (bit_cnt_reg == STOP_LAST) begin
            complete   = 1'b1;
            state_next = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
            frame_is_break = (shift_reg == '0) && !par_bit_reg && frame_ferr;
            if (frame_is_break) begin
              state_next = BREAK;
              break_next = 1'b1;
            end
`endif
          end else begin
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            ferr_acc_next = ferr_acc_reg | ~vote;
          end
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
          break_next = 1'b0;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase

    // Output handshake: a completion may reload in the same cycle the old
    // word is accepted; otherwise an occupied output drops the new frame.
    deliver = complete & ~frame_is_break;
    if (valid_reg && ready) begin
      valid_next = 1'b0;
    end
    if (deliver) begin
      if (!valid_reg || ready) begin
        data_next  = shift_reg;
        perr_next  = frame_perr;
        ferr_next  = frame_ferr;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  assign data        = data_reg;
  assign valid       = valid_reg;
  assign parity_err  = perr_reg;
  assign framing_err = ferr_reg;
  assign overrun     = overrun_reg;
  assign busy        = (state_reg != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_o     = break_reg;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg.
//   dut0: defaults (8N1, 16x oversample, 432 clk/bit)
//   dut1: 8 data bits, even parity, 2 stop bits, 8x oversample, 48 clk/bit
// Stimulus pushes the expected word into a per-DUT queue; a monitor pops and
// compares whenever valid && ready is seen.
module tb_uart_rx_cfg;

  localparam int BIT0 = 432;
  localparam int BIT1 = 48;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] rx_l;
  logic [1:0] ready_l;

  logic [7:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       brk0, brk1;
`endif

  int   tests;
  int   fails;
  int   cyc;
  int   ovr_cnt [2];
  int   rise_cyc[2];
  logic prev_v  [2];
  exp_t q0[$];
  exp_t q1[$];

  uart_rx_cfg dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_l[0]),
    .data        (data0),
    .valid       (valid0),
    .ready       (ready_l[0]),
    .parity_err  (perr0),
    .framing_err (ferr0),
    .overrun     (ovr0),
    .busy        (busy0)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_o     (brk0)
`endif
  );

  uart_rx_cfg #(
    .BAUD       (1_000_000),
    .OVERSAMPLE (8),
    .PARITY     (1),
    .STOP_BITS  (2)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_l[1]),
    .data        (data1),
    .valid       (valid1),
    .ready       (ready_l[1]),
    .parity_err  (perr1),
    .framing_err (ferr1),
    .overrun     (ovr1),
    .busy        (busy1)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_o     (brk1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if ((act < lo) || (act > hi)) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: frame fields straight from the line format.
  function automatic exp_t model(input int idx, input logic [7:0] d, input logic pbit,
                                 input logic [1:0] stops);
    exp_t e;
    int   ones;
    e.d  = d;
    ones = $countones(d) + int'(pbit);
    e.pe = (idx == 1) ? ((ones % 2) != 0) : 1'b0;
    e.fe = (idx == 1) ? !(stops[0] && stops[1]) : !stops[0];
    return e;
  endfunction

  function automatic int bit_clk(input int idx);
    return (idx == 0) ? BIT0 : BIT1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame on rx_l[idx]; stops after max_clk clocks if shorter.
  task automatic drive_frame(input int idx, input logic [7:0] d, input logic pbit,
                             input logic [1:0] stops, input int max_clk);
    logic [15:0] bits;
    int          n;
    int          bc;
    bits = '0;
    n    = 1;  // bit 0 = start = 0
    bc   = bit_clk(idx);
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (idx == 1) begin
      bits[n] = pbit;
      n++;
    end
    for (int s = 0; s < ((idx == 1) ? 2 : 1); s++) begin
      bits[n] = stops[s];
      n++;
    end
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < bc; c++) begin
        if ((b * bc + c) >= max_clk) return;
        rx_l[idx] = bits[b];
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic pbit,
                      input logic [1:0] stops, input logic push_exp, input int gap_bits);
    exp_t e;
    logic brk;
    e   = model(idx, d, pbit, stops);
    brk = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk = (d == 8'h00) && ((idx == 0) || !pbit) && e.fe;
`endif
    if (push_exp && !brk) begin
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    drive_frame(idx, d, pbit, stops, 1 << 30);
    if (gap_bits > 0) begin
      rx_l[idx] = 1'b1;
      wait_clk(gap_bits * bit_clk(idx));
    end
  endtask

  task automatic mon(input int idx, input logic v, input logic r, input logic [7:0] d,
                     input logic pe, input logic fe, input logic ov);
    exp_t e;
    logic have;
    if (ov) ovr_cnt[idx]++;
    if (v && !prev_v[idx]) rise_cyc[idx] = cyc;
    prev_v[idx] = v;
    if (v && r) begin
      have = (idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        tests++;
        fails++;
        $display("FAIL dut%0d unexpected_valid: got data 0x%0h, expected no output", idx, d);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("dut%0d data", idx), 32'(d), 32'(e.d));
        check($sformatf("dut%0d parity_err", idx), 32'(pe), 32'(e.pe));
        check($sformatf("dut%0d framing_err", idx), 32'(fe), 32'(e.fe));
        $display("[TB] dut%0d rx data=0x%02h pe=%0b fe=%0b (exp 0x%02h %0b %0b)",
                 idx, d, pe, fe, e.d, e.pe, e.fe);
      end
    end
  endtask

  initial begin
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(0, valid0, ready_l[0], data0, perr0, ferr0, ovr0);
        mon(1, valid1, ready_l[1], data1, perr1, ferr1, ovr1);
      end else begin
        prev_v[0] = 1'b0;
        prev_v[1] = 1'b0;
      end
    end
  end

  initial begin
    int start_cyc;
    int ovr_base;
    tests      = 0;
    fails      = 0;
    ovr_cnt[0] = 0;
    ovr_cnt[1] = 0;
    rise_cyc[0] = 0;
    rise_cyc[1] = 0;
    rst_n   = 1'b0;
    rx_l    = 2'b11;
    ready_l = 2'b11;
    wait_clk(5);

    // Reset state
    check("rst valid0", 32'(valid0), 0);
    check("rst busy0", 32'(busy0), 0);
    check("rst data0", 32'(data0), 0);
    check("rst flags0", 32'({perr0, ferr0, ovr0}), 0);
    check("rst valid1", 32'(valid1), 0);
    check("rst busy1", 32'(busy1), 0);
`ifdef UART_RX_BREAK_DETECT_EN
    check("rst break", 32'({brk0, brk1}), 0);
`endif
    rst_n = 1'b1;
    wait_clk(50);

    // 8N1 byte 0x0F; valid must rise at the stop-bit centre, not its end
    start_cyc = cyc;
    send(0, 8'h0F, 1'b0, 2'b11, 1'b1, 2);
    check_range("dut0 latency", rise_cyc[0] - start_cyc, 9 * BIT0 + BIT0 / 4, 9 * BIT0 + 3 * BIT0 / 4 + 8);
    check("dut0 no overrun", 32'(ovr_cnt[0]), 0);

    // Even parity: good and bad parity bit on 0xA5
    start_cyc = cyc;
    send(1, 8'hA5, 1'b0, 2'b11, 1'b1, 2);
    check_range("dut1 latency", rise_cyc[1] - start_cyc, 11 * BIT1 + BIT1 / 4, 11 * BIT1 + 3 * BIT1 / 4 + 8);
    send(1, 8'hA5, 1'b1, 2'b11, 1'b1, 2);
    send(1, 8'h3C, 1'b0, 2'b01, 1'b1, 2);  // second stop bit low

    // Overrun: consumer stalled, two back-to-back frames
    ready_l[0] = 1'b0;
    ovr_base   = ovr_cnt[0];
    send(0, 8'h11, 1'b0, 2'b11, 1'b1, 0);
    send(0, 8'h22, 1'b0, 2'b11, 1'b0, 1);
    check("overrun pulses", 32'(ovr_cnt[0] - ovr_base), 1);
    check("held valid", 32'(valid0), 1);
    check("held data", 32'(data0), 32'h11);
    ready_l[0] = 1'b1;
    wait_clk(1);
    check("valid after accept", 32'(valid0), 0);

    // Glitch: 100 clk low pulse is a false start
    rx_l[0] = 1'b0;
    wait_clk(50);
    check("glitch busy", 32'(busy0), 1);
    wait_clk(50);
    rx_l[0] = 1'b1;
    wait_clk(BIT0);
    check("glitch busy clear", 32'(busy0), 0);

    // Framing error, then line held low: no further frames
    send(0, 8'h55, 1'b0, 2'b10, 1'b1, 0);
    wait_clk(5000);
    check("low line idle", 32'(busy0), 0);
    rx_l[0] = 1'b1;
    wait_clk(BIT0);

    // All-zero frame with low stop bit (break)
    send(0, 8'h00, 1'b0, 2'b10, 1'b1, 0);
    wait_clk(1000);
`ifdef UART_RX_BREAK_DETECT_EN
    check("break_o set", 32'(brk0), 1);
    rx_l[0] = 1'b1;
    wait_clk(10);
    check("break_o clear", 32'(brk0), 0);
`else
    rx_l[0] = 1'b1;
    wait_clk(10);
`endif
    check("break busy clear", 32'(busy0), 0);
    wait_clk(BIT0);

    // Reset 1000 clk into a frame, then a clean frame
    drive_frame(0, 8'h00, 1'b0, 2'b11, 1000);
    check("mid-frame busy", 32'(busy0), 1);
    rst_n = 1'b0;
    wait_clk(3);
    check("mid-frame rst valid", 32'(valid0), 0);
    check("mid-frame rst busy", 32'(busy0), 0);
    rx_l[0] = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(BIT0);
    send(0, 8'hC3, 1'b0, 2'b11, 1'b1, 2);

    // Randomised frames on both receivers in parallel
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic [1:0] st;
          st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
          send(0, 8'($urandom_range(0, 255)), 1'b0, st, 1'b1, 1);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          logic [1:0] st;
          st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
          send(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), st, 1'b1, 2);
        end
      end
    join

    wait_clk(2000);
    check("dut0 queue drained", 32'(q0.size()), 0);
    check("dut1 queue drained", 32'(q1.size()), 0);
    check("dut0 total overruns", 32'(ovr_cnt[0]), 1);
    check("dut1 total overruns", 32'(ovr_cnt[1]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised next-generation UART receiver for the host serial link.
Generalises the fixed 8N1 receiver with:
- configurable data width, parity and stop bits;
- 3-sample majority voting;
- a valid/ready output handshake with overrun, parity and framing reporting.
Sits between the board RX pin and the command/packet parser.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bits/s
OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_i  in  1  raw serial line, asynchronous to clk; idles high
data  out  DATA_BITS  received payload, LSB = first bit received
valid  out  1  data and its flags are available
ready  in  1  consumer accepts the current data
parity_err  out  1  parity mismatch for the presented data; qualified by valid
framing_err  out  1  stop bit sampled low for the presented data; qualified by valid
overrun  out  1  one-cycle pulse: a frame was dropped because the output was still occupied
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; FSM in IDLE; synchroniser stages and previous-sample register set to 1.
- Input conditioning:
  - rx_i passes through a 2-FF synchroniser.
  - All decisions use the synchronised value.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer division; DIV >= 2 is a parameter check (elaboration error otherwise).
  - Defaults: DIV = 27, one bit = 432 clk.
  - The tick counter runs freely, but is cleared on start detection so sampling phase aligns to the start edge.
- Bit sampling:
  - Each bit's value is the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
  - Bit boundaries fall every OVERSAMPLE ticks.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START: synchronised line goes high-to-low. A line that is merely held low does not retrigger.
  - START: at the mid-bit vote:
    - voted 1 -> false start, return to IDLE, no output, no flags;
    - voted 0 -> DATA.
  - DATA: shift in DATA_BITS voted bits, LSB first. Then go to PAR if PARITY != 0, else STOP.
  - PAR: voted bit compared with computed parity:
    - even: XOR of data bits plus parity bit must be 0;
    - odd: that XOR must be 1.
  - STOP: vote each stop bit. Any stop bit low sets the frame's framing error.
- Frame completion:
  - The frame completes at the mid-bit vote of the last stop bit, not at its end, so back-to-back frames are not missed.
  - On completion the FSM returns to IDLE.
  - If the line is still low (break or framing fault), the next start requires a fresh high-to-low edge.
- Output handshake:
  - Completion with valid == 0 or (valid && ready) in the same cycle: next cycle data, parity_err and framing_err load, and valid = 1.
  - Completion with valid && !ready: frame discarded, old data and flags held, overrun pulses for 1 cycle.
  - valid && ready with no completion: valid clears next cycle.
  - data and flags are stable while valid && !ready.
- Latency: valid rises 1 clk after the last-stop-bit mid-sample tick.
- Reset mid-frame: immediate return to IDLE, partial frame discarded, valid cleared.

Optional Feature:
Macro: UART_RX_BREAK_DETECT_EN
Defined:
- Adds output port break_o (1 bit, reset 0).
- If a completed frame has all data bits 0, parity (if any) 0 and stop bit low, the FSM enters an extra BREAK state. The frame is not presented on data.
- break_o is held high until the synchronised line returns high; then the FSM goes to IDLE.
Undefined:
- No break_o port and no BREAK state.
- That frame is delivered normally with framing_err = 1.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - rx_state_e enum;
  - function for DIV computation.
- One sub-module, uart_baud_tick: counter producing the oversample tick with a synchronous clear input. It will be reused by the future uart_tx_cfg.
- Synchroniser and majority vote stay inline.

Test Plan:
- Defaults (8N1), ready = 1, line driven at 432 clk/bit, byte 0x0F -> one valid pulse with data = 0x0F, parity_err = 0, framing_err = 0, overrun = 0.
- PARITY = 1 (even), byte 0xA5 with parity bit 0 -> data = 0xA5, parity_err = 0. Same byte with parity bit 1 -> parity_err = 1, data = 0xA5.
- ready held 0; frames 0x11 then 0x22 back-to-back -> data stays 0x11, one overrun pulse. After ready = 1 for 1 clk, valid = 0.
- Glitch: 100 clk low pulse on an idle line -> false start, no valid, busy returns 0 within 432 clk.
- Frame 0x55 with stop bit driven 0 -> valid with framing_err = 1. Line then held low for 5000 clk -> no further frames (break_o = 1 when UART_RX_BREAK_DETECT_EN is defined and data is 0x00).
- rst_n asserted 1000 clk into a frame, released, then 0xC3 sent -> data = 0xC3, no stale flags.
